// File: rtl/down_counter_timer_pkg.sv
// Shared types and constants for the down-counting timer and its prescaler.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  // Prescaler counter width; bounds PRESCALE to 1..255.
  localparam int PS_W = 8;

endpackage : timer_pkg

// File: rtl/down_counter_timer_if.sv
// Control/status bundle between upper logic (master) and the timer (slave).
// Handshake: no valid/ready; load is a single-cycle strobe sampled on the clk edge,
// enable/auto_reload are levels, and every status output is valid every cycle.
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  import timer_pkg::*;

  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             tc_pulse;
  logic             busy;
  state_t           state;

  modport master (
    output enable, load, load_value, auto_reload,
    input  out, zero, tc_pulse, busy, state
  );

  modport slave (
    input  enable, load, load_value, auto_reload,
    output out, zero, tc_pulse, busy, state
  );

endinterface : down_counter_timer_if

// File: rtl/down_counter_timer_prescaler.sv
// Divides enabled clock cycles down to one tick every PRESCALE enabled cycles.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  logic [PS_W-1:0] cnt_q;
  logic            at_last;

  assign at_last = (cnt_q == PS_W'(PRESCALE - 1));
  assign tick    = enable && !clear && at_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (at_last) cnt_q <= '0;
      else         cnt_q <= cnt_q + PS_W'(1);
    end
  end

endmodule : tick_prescaler

// File: rtl/down_counter_timer.sv
// Loadable down-counter with prescaled ticks, one-cycle terminal-count pulse and
// one-shot (hold at zero) or periodic (reload) behaviour.
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  down_counter_timer_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             ps_clear;

  // The prescaler only runs in RUN and restarts its phase on every load.
  assign ps_clear = bus.load || (state_q != RUN);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .clear  (ps_clear),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.load) begin
      count_d  = bus.load_value;
      reload_d = bus.load_value;
      state_d  = (bus.load_value != '0) ? RUN : IDLE;
    end else if (state_q == RUN && tick) begin
      // RUN always holds a count >= 1, so the decrement never wraps.
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        if (bus.auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = EXPIRED;
        end
      end
    end
  end

  assign bus.out      = count_q;
  assign bus.zero     = (count_q == '0);
  assign bus.tc_pulse = tc_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.state    = state_q;

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: PRESCALE=1 and PRESCALE=3 instances share stimulus.
module tb_down_counter_timer;
  import timer_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  down_counter_timer_if #(.WIDTH(W)) if0 ();
  down_counter_timer_if #(.WIDTH(W)) if3 ();

  down_counter_timer #(.WIDTH(W), .PRESCALE(1)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  down_counter_timer #(.WIDTH(W), .PRESCALE(3)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));

  // Shared stimulus drivers
  logic         enable, load, auto_reload;
  logic [W-1:0] load_value;
  assign if0.enable = enable;  assign if3.enable = enable;
  assign if0.load = load;      assign if3.load = load;
  assign if0.load_value = load_value;  assign if3.load_value = load_value;
  assign if0.auto_reload = auto_reload; assign if3.auto_reload = auto_reload;

  // Reference model: count, reload value, running/expired flags and enabled cycles since last tick.
  int m_cnt[2], m_rel[2], m_elapsed[2], m_tc[2];
  bit m_running[2], m_expired[2];
  int m_pre[2] = '{1, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_tc[k] = 0;
      if (reset) begin
        m_cnt[k] = 0; m_rel[k] = 0; m_elapsed[k] = 0;
        m_running[k] = 0; m_expired[k] = 0;
      end else if (load) begin
        m_cnt[k] = int'(load_value); m_rel[k] = int'(load_value); m_elapsed[k] = 0;
        m_running[k] = (load_value != 0); m_expired[k] = 0;
      end else if (m_running[k] && enable) begin
        m_elapsed[k]++;
        if (m_elapsed[k] == m_pre[k]) begin
          m_elapsed[k] = 0;
          if (m_cnt[k] > 1) m_cnt[k]--;
          else begin
            m_tc[k] = 1;
            if (auto_reload) m_cnt[k] = m_rel[k];
            else begin
              m_cnt[k] = 0; m_running[k] = 0; m_expired[k] = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic chk_inst(input int k, input logic [W-1:0] o, input logic z, input logic tc,
                          input logic b, input state_t st);
    int exp_st;
    exp_st = m_running[k] ? 1 : (m_expired[k] ? 2 : 0);
    chk($sformatf("p%0d.out", m_pre[k]), 32'(o), 32'(m_cnt[k]));
    chk($sformatf("p%0d.zero", m_pre[k]), 32'(z), 32'(m_cnt[k] == 0));
    chk($sformatf("p%0d.tc", m_pre[k]), 32'(tc), 32'(m_tc[k]));
    chk($sformatf("p%0d.busy", m_pre[k]), 32'(b), 32'(m_running[k]));
    chk($sformatf("p%0d.state", m_pre[k]), 32'(st), 32'(exp_st));
  endtask

  // Advance one clock edge and compare both instances with the model.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk_inst(0, if0.out, if0.zero, if0.tc_pulse, if0.busy, if0.state);
    chk_inst(1, if3.out, if3.zero, if3.tc_pulse, if3.busy, if3.state);
  endtask

  task automatic drive(input logic r, input logic l, input logic [W-1:0] lv,
                       input logic en, input logic ar);
    reset = r; load = l; load_value = lv; enable = en; auto_reload = ar;
  endtask

  initial begin
    int seq3[6];
    seq3 = '{2, 1, 3, 2, 1, 3};

    // 1. Reset with random inputs, then idle without load
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    chk("rst.out", 32'(if0.out), 0);
    chk("rst.zero", 32'(if0.zero), 1);
    chk("rst.busy", 32'(if0.busy), 0);
    chk("rst.tc", 32'(if0.tc_pulse), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, W'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    chk("idle.state", 32'(if0.state), 32'(IDLE));

    // 2. One-shot from 5 at PRESCALE=1
    drive(1'b0, 1'b1, 4'd5, 1'b0, 1'b0); step();
    chk("os.load", 32'(if0.out), 5);
    chk("os.busy0", 32'(if0.busy), 1);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int v = 4; v >= 0; v--) begin
      step();
      chk("os.seq", 32'(if0.out), 32'(v));
      chk("os.tc", 32'(if0.tc_pulse), 32'(v == 0));
      chk("os.busy", 32'(if0.busy), 32'(v != 0));
    end
    for (int i = 0; i < 10; i++) begin
      step();
      chk("os.hold", 32'(if0.out), 0);
      chk("os.hold_tc", 32'(if0.tc_pulse), 0);
    end
    chk("os.expired", 32'(if0.state), 32'(EXPIRED));

    // 3. Periodic from 3
    drive(1'b0, 1'b1, 4'd3, 1'b1, 1'b1); step();
    chk("per.load", 32'(if0.out), 3);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("per.seq", 32'(if0.out), 32'(seq3[i]));
      chk("per.tc", 32'(if0.tc_pulse), 32'(seq3[i] == 3));
      chk("per.zero", 32'(if0.zero), 0);
    end

    // 4. Enable freeze at 2
    drive(1'b0, 1'b1, 4'd9, 1'b1, 1'b0); step();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step();
    chk("frz.at2", 32'(if0.out), 2);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("frz.hold", 32'(if0.out), 2);
      chk("frz.tc", 32'(if0.tc_pulse), 0);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    step(); chk("frz.one", 32'(if0.out), 1);
    step(); chk("frz.zero", 32'(if0.out), 0); chk("frz.tcz", 32'(if0.tc_pulse), 1);

    // 5. Load colliding with terminal tick, then load 0
    drive(1'b0, 1'b1, 4'd2, 1'b1, 1'b0); step();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0); step();
    chk("col.at1", 32'(if0.out), 1);
    drive(1'b0, 1'b1, 4'd7, 1'b1, 1'b0); step();
    chk("col.out", 32'(if0.out), 7);
    chk("col.tc", 32'(if0.tc_pulse), 0);
    chk("col.busy", 32'(if0.busy), 1);
    drive(1'b0, 1'b1, 4'd0, 1'b1, 1'b0); step();
    chk("ld0.out", 32'(if0.out), 0);
    chk("ld0.state", 32'(if0.state), 32'(IDLE));
    chk("ld0.busy", 32'(if0.busy), 0);
    chk("ld0.tc", 32'(if0.tc_pulse), 0);

    // 6. PRESCALE=3 from 2, then reset with load high mid-count
    drive(1'b0, 1'b1, 4'd2, 1'b1, 1'b0); step();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("ps3.out", 32'(if3.out), 32'((i < 3) ? 2 : ((i < 6) ? 1 : 0)));
      chk("ps3.tc", 32'(if3.tc_pulse), 32'(i == 6));
    end
    drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b0); step();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0); step(); step();
    drive(1'b1, 1'b1, 4'd9, 1'b1, 1'b0); step();
    chk("rstmid.out0", 32'(if0.out), 0);
    chk("rstmid.out3", 32'(if3.out), 0);
    chk("rstmid.busy3", 32'(if3.busy), 0);

    // Random soak against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 9) == 0), W'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_down_counter_timer

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable down-counting timer. It is the count-down counterpart of the team's 4-bit enable-gated up counter.
- Software/upper logic loads a start value; the block decrements on enabled prescaled ticks.
- It flags terminal count with a one-cycle pulse, then either holds at zero (one-shot) or reloads (periodic).
- Used as the timeout/period generator beside the up counter in the HW3 datapath.

Parameters:
WIDTH, 4, counter and load value width in bits
PRESCALE, 1, number of enabled clk cycles per decrement tick (legal range 1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  count enable; 0 freezes counter and prescaler
load  input  1  load strobe; captures load_value into count and reload register
load_value  input  WIDTH  start/reload value
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode (sampled at each terminal tick)
out  output  WIDTH  current count (registered)
zero  output  1  level, high when out == 0
tc_pulse  output  1  one-cycle pulse at terminal count (registered)
busy  output  1  high while in RUN state

Behaviour:
- One clock domain. Reset is synchronous and active-high on reset, sampled at the clk rising edge. Reset overrides all other inputs.
- Reset values:
  - out=0, zero=1, tc_pulse=0, busy=0
  - state=IDLE, reload register=0, prescaler count=0
- States:
  - IDLE: never loaded or loaded with 0.
  - RUN: counting.
  - EXPIRED: one-shot finished, holds 0.
- Priority per edge: reset > load > tick > hold.
- Load (any state, enable ignored):
  - out<=load_value, reload register<=load_value, prescaler cleared, tc_pulse<=0.
  - Next state is RUN if load_value!=0, else IDLE.
  - Visible on out the cycle after the load edge (1-cycle latency).
- Tick generation:
  - The prescaler counts enabled cycles 0..PRESCALE-1 while in RUN.
  - tick is asserted on the enabled cycle where the prescaler count equals PRESCALE-1; the prescaler then wraps to 0.
  - PRESCALE=1 means a tick on every enabled cycle.
  - The prescaler holds when enable=0 and clears on leaving RUN.
- RUN with tick:
  - out>1: out<=out-1.
  - out==1 and auto_reload=0: out<=0, tc_pulse<=1, next state EXPIRED.
  - out==1 and auto_reload=1: out<=reload register, tc_pulse<=1, stay RUN. out never shows 0 in periodic mode.
- tc_pulse is high for exactly one cycle, coincident with the updated out value. It is 0 on every cycle without a terminal tick.
- EXPIRED and IDLE: out holds; the block leaves these states only on load.
- Arithmetic: unsigned, WIDTH bits. No wrap below 0 is ever possible, because decrement occurs only from out>=2.
- zero is combinational from out. busy = (state==RUN).
- Load and terminal tick in the same cycle: load wins; no tc_pulse.
- Reset mid-count, even with load high: reset values after that edge.

Decomposition:
- Shared package timer_pkg holds:
  - state typedef with encodings IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2
  - PRESCALE width constant (8 bits)
- One sub-module, tick_prescaler (clk, reset, enable, clear, tick), parameterised by PRESCALE.
- Top level holds the FSM, count register and reload register.

Test Plan:
1. Reset high for 2 cycles with random inputs -> out=0, zero=1, busy=0, tc_pulse=0; state stays IDLE afterward with no load.
2. WIDTH=4, PRESCALE=1, auto_reload=0: load 5, then enable=1 -> out 5,4,3,2,1,0 on consecutive edges.
   - tc_pulse=1 only in the cycle out becomes 0; busy falls with it.
   - out holds 0 for 10 further cycles.
3. auto_reload=1, load 3, enable=1 -> out sequence 3,2,1,3,2,1,3.
   - tc_pulse high on each reload to 3, i.e. every 3 cycles.
   - zero never asserts.
4. Count from 9; deassert enable when out=2 for 7 cycles -> out stays 2, no tc_pulse; re-enable gives 1 then 0 with tc_pulse.
5. Load 7 asserted in the same cycle out==1 would terminal-tick -> next out=7, tc_pulse=0, busy=1.
   - Separately, load 0 -> out=0, state IDLE, busy=0, no tc_pulse.
6. PRESCALE=3, load 2, enable continuous -> out drops to 1 after 3 cycles and to 0 after 6, with tc_pulse.
   - Assert reset with load=1 mid-count -> out=0 next edge.
